// File: rtl/lsu_uart_tx_if.sv
// ============================================================================
// Module   : lsu_uart_tx_if
// Purpose  : LSU data-memory bus bundle between the core and the UART window.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface lsu_uart_tx_if;
  logic        cs;
  logic        wr;
  logic [3:0]  mask;
  logic [31:0] addr;
  logic [31:0] data_wr;
  logic [31:0] data_rd;

  modport master (output cs, wr, mask, addr, data_wr, input data_rd);
  modport slave  (input cs, wr, mask, addr, data_wr, output data_rd);
endinterface

`default_nettype wire

// File: rtl/lsu_uart_tx.sv
// ============================================================================
// Module   : lsu_uart_tx
// Purpose  : Memory-mapped 8N1 UART transmitter with TX FIFO on the LSU bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  lsu_uart_tx_if.slave     bus,
  output logic             tx,
  output logic             irq
);

  localparam int             c_aw       = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0]  c_full_cnt = (c_aw+1)'(FIFO_DEPTH);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_start = 2'd1;
  localparam logic [1:0] c_st_data  = 2'd2;
  localparam logic [1:0] c_st_stop  = 2'd3;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [c_aw-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_aw:0]   r_count;
  logic            r_ovf;
  logic [15:0]     r_div;
  logic            r_enable, r_irq_en;
  logic [1:0]      r_state;
  logic [7:0]      r_shift;
  logic [2:0]      r_bitcnt;
  logic [15:0]     r_baudcnt;
  logic [15:0]     r_bit_div;
  logic            r_tx, r_irq;

  logic        w_hit, w_wr, w_rd;
  logic [1:0]  w_sel;
  logic        w_full, w_empty, w_busy;
  logic        w_push_req, w_push, w_pop, w_ovf_set, w_can_pop;
  logic [15:0] w_div_eff;
  logic        w_bit_end;
  logic [31:0] w_count32;
  logic [3:0]  w_cnt_sat;
  logic        w_unused;

  assign w_hit   = bus.cs & (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign w_wr    = w_hit & bus.wr;
  assign w_rd    = w_hit & ~bus.wr;
  assign w_sel   = bus.addr[3:2];
  assign w_full  = (r_count == c_full_cnt);
  assign w_empty = (r_count == '0);
  assign w_busy  = (r_state != c_st_idle);

  assign w_div_eff = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_bit_end = (r_baudcnt == r_bit_div - 16'd1);
  assign w_can_pop = r_enable & ~w_empty;
  assign w_pop     = w_can_pop & ((r_state == c_st_idle) |
                                  ((r_state == c_st_stop) & w_bit_end));

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_push_req = w_wr & (w_sel == 2'd0) & bus.mask[0];
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf_set  = w_push_req & w_full & ~w_pop;

  assign w_count32 = 32'(r_count);
  assign w_cnt_sat = (w_count32 > 32'd15) ? 4'hF : w_count32[3:0];

  assign w_unused = &{1'b0, bus.addr[1:0], bus.mask[3:2], bus.data_wr[31:16]};

  always_comb begin
    bus.data_rd = 32'd0;
    if (w_rd) begin
      case (w_sel)
        2'd1:    bus.data_rd = {24'd0, w_cnt_sat, r_ovf, w_busy, w_empty, w_full};
        2'd2:    bus.data_rd = {16'd0, r_div};
        2'd3:    bus.data_rd = {30'd0, r_irq_en, r_enable};
        default: bus.data_rd = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.data_wr[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_div    <= DEFAULT_DIV;
      r_enable <= 1'b1;
      r_irq_en <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      if (w_push & ~w_pop)      r_count <= r_count + (c_aw+1)'(1);
      else if (w_pop & ~w_push) r_count <= r_count - (c_aw+1)'(1);

      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (w_wr && w_sel == 2'd1 && bus.mask[0] && bus.data_wr[3])
        r_ovf <= 1'b0;

      if (w_wr && w_sel == 2'd2) begin
        if (bus.mask[0]) r_div[7:0]  <= bus.data_wr[7:0];
        if (bus.mask[1]) r_div[15:8] <= bus.data_wr[15:8];
      end
      if (w_wr && w_sel == 2'd3 && bus.mask[0]) begin
        r_enable <= bus.data_wr[0];
        r_irq_en <= bus.data_wr[1];
      end
    end
  end

  // Bit period is re-sampled at every bit boundary so BAUDDIV writes apply to the next bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= c_st_idle;
      r_shift   <= 8'd0;
      r_bitcnt  <= 3'd0;
      r_baudcnt <= 16'd0;
      r_bit_div <= DEFAULT_DIV;
      r_tx      <= 1'b1;
      r_irq     <= 1'b0;
    end else begin
      r_irq <= r_irq_en & w_empty & (r_state == c_st_idle);
      case (r_state)
        c_st_idle: begin
          if (w_can_pop) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_bitcnt  <= 3'd0;
            r_baudcnt <= 16'd0;
            r_bit_div <= w_div_eff;
            r_tx      <= 1'b0;
            r_state   <= c_st_start;
          end
        end
        c_st_start: begin
          if (w_bit_end) begin
            r_baudcnt <= 16'd0;
            r_bit_div <= w_div_eff;
            r_tx      <= r_shift[0];
            r_state   <= c_st_data;
          end else begin
            r_baudcnt <= r_baudcnt + 16'd1;
          end
        end
        c_st_data: begin
          if (w_bit_end) begin
            r_baudcnt <= 16'd0;
            r_bit_div <= w_div_eff;
            if (r_bitcnt == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= c_st_stop;
            end else begin
              r_shift  <= {1'b0, r_shift[7:1]};
              r_tx     <= r_shift[1];
              r_bitcnt <= r_bitcnt + 3'd1;
            end
          end else begin
            r_baudcnt <= r_baudcnt + 16'd1;
          end
        end
        c_st_stop: begin
          if (w_bit_end) begin
            r_baudcnt <= 16'd0;
            r_bit_div <= w_div_eff;
            if (w_can_pop) begin
              r_shift  <= r_mem[r_rd_ptr];
              r_bitcnt <= 3'd0;
              r_tx     <= 1'b0;
              r_state  <= c_st_start;
            end else begin
              r_state <= c_st_idle;
            end
          end else begin
            r_baudcnt <= r_baudcnt + 16'd1;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign tx  = r_tx;
  assign irq = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_lsu_uart_tx.sv
// ============================================================================
// Module   : tb_lsu_uart_tx
// Purpose  : Directed self-checking bench for lsu_uart_tx.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_uart_tx;
  localparam logic [31:0] c_txdata = 32'h8000_0000;
  localparam logic [31:0] c_status = 32'h8000_0004;
  localparam logic [31:0] c_baud   = 32'h8000_0008;
  localparam logic [31:0] c_ctrl   = 32'h8000_000C;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx, irq;
  int   n_total = 0;
  int   n_bad   = 0;

  lsu_uart_tx_if bus ();

  lsu_uart_tx #(
    .BASE_ADDR   (32'h8000_0000),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tx  (tx),
    .irq (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.data_wr = d; bus.mask = m;
    @(posedge clk);
    #1;
    bus.cs = 1'b0; bus.wr = 1'b0; bus.mask = 4'h0;
  endtask

  task automatic rd_now(input logic [31:0] a, output logic [31:0] d);
    bus.cs = 1'b1; bus.wr = 1'b0; bus.addr = a;
    #1;
    d = bus.data_rd;
    bus.cs = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    rd_now(a, d);
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  b;
    logic [7:0]  exp_bytes [10];
    logic        e;
    bus.cs = 1'b0; bus.wr = 1'b0; bus.mask = 4'h0; bus.addr = 32'h0; bus.data_wr = 32'h0;
    exp_bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h19, 8'h1A};

    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Reset state
    rd(c_status, v); check("rst_status", v, 32'h2);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rd(c_baud, v);   check("rst_baud", v, 32'd16);
    rd(c_ctrl, v);   check("rst_ctrl", v, 32'd1);

    // Single frame 0xA5 at div=4
    bus_wr(c_baud, 32'd4, 4'b0011);
    rd(c_baud, v); check("baud4", v, 32'd4);
    b = 8'hA5;
    bus_wr(c_txdata, 32'hA5, 4'b0001);
    for (int k = 0; k <= 41; k++) begin
      @(negedge clk);
      if (k == 0 || k >= 37)  e = 1'b1;
      else if (k <= 4)        e = 1'b0;
      else                    e = b[(k - 5) / 4];
      check($sformatf("a5_tx_k%0d", k), {31'd0, tx}, {31'd0, e});
      rd_now(c_status, v);
      check($sformatf("a5_busy_k%0d", k), {31'd0, v[2]}, (k >= 1 && k <= 40) ? 32'd1 : 32'd0);
    end

    // Overflow with enable=0
    bus_wr(c_ctrl, 32'd0, 4'b0001);
    bus_wr(c_baud, 32'd2, 4'b0011);
    for (int i = 0; i < 9; i++) bus_wr(c_txdata, 32'h10 + i, 4'b0001);
    rd(c_status, v); check("ovf_status", v, 32'h89);
    bus_wr(c_status, 32'h0, 4'b0001);
    rd(c_status, v); check("w1c_zero_keeps", v, 32'h89);
    bus_wr(c_status, 32'h8, 4'b0001);
    rd(c_status, v); check("ovf_cleared", v, 32'h81);

    // Enable: back-to-back frames, pushes coinciding with pops while full
    bus_wr(c_ctrl, 32'd1, 4'b0001);
    fork
      begin
        for (int k = 0; k <= 205; k++) begin
          @(negedge clk);
          if (k == 0 || k > 200) e = 1'b1;
          else begin
            int pos, slot;
            pos  = (k - 1) % 20;
            slot = pos / 2;
            b    = exp_bytes[(k - 1) / 20];
            if (slot == 0)      e = 1'b0;
            else if (slot == 9) e = 1'b1;
            else                e = b[slot - 1];
          end
          check($sformatf("stream_tx_k%0d", k), {31'd0, tx}, {31'd0, e});
        end
      end
      begin
        logic [31:0] s;
        bus_wr(c_txdata, 32'h19, 4'b0001);
        repeat (19) @(posedge clk);
        bus_wr(c_txdata, 32'h1A, 4'b0001);
        rd(c_status, s); check("full_pop_push", s, 32'h85);
      end
    join
    rd(c_status, v); check("drained", v, 32'h2);

    // Asynchronous reset in the middle of data bit 3
    bus_wr(c_baud, 32'd4, 4'b0011);
    bus_wr(c_txdata, 32'h00, 4'b0001);
    bus_wr(c_txdata, 32'h55, 4'b0001);
    repeat (17) @(negedge clk);
    check("bit3_low", {31'd0, tx}, 32'd0);
    rst = 1'b0;
    #1;
    check("async_tx", {31'd0, tx}, 32'd1);
    rd_now(c_status, v); check("inrst_status", v, 32'h2);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rd_now(c_status, v); check("post_rst_status", v, 32'h2);
    check("post_rst_tx", {31'd0, tx}, 32'd1);
    rd(c_baud, v); check("post_rst_baud", v, 32'd16);
    rd(c_ctrl, v); check("post_rst_ctrl", v, 32'd1);

    // Decode misses, byte-lane qualification, irq
    bus_wr(32'h8000_0010, 32'h77, 4'hF);
    bus_wr(c_txdata, 32'h77, 4'b0010);
    rd(c_status, v); check("no_push", v, 32'h2);
    rd(32'h8000_0014, v); check("miss_rd", v, 32'h0);
    rd(c_txdata, v); check("txdata_rd", v, 32'h0);
    check("irq_off", {31'd0, irq}, 32'd0);
    bus_wr(c_ctrl, 32'd3, 4'b0001);
    repeat (2) @(negedge clk);
    check("irq_on", {31'd0, irq}, 32'd1);
    rd(c_ctrl, v); check("ctrl3", v, 32'd3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/lsu_uart_tx.md
Name: lsu_uart_tx

Overview:
- Memory-mapped UART transmitter that responds on the LSU data-memory bus (cs/wr/mask/addr/data_wr/data_rd), alongside the data memory.
- The core is the initiator on this bus; this block is a responder to core loads and stores.
- Stores to TXDATA push bytes into a TX FIFO. A bit-serial 8N1 engine drains the FIFO onto `tx`.
- Used by compliance and debug software to emit characters and signatures off-chip.

Parameters:
- BASE_ADDR, 32'h8000_0000, base of the 16-byte register window. Only addr[31:4] is compared.
- FIFO_DEPTH, 8, TX FIFO entries. Must be a power of two, ≥2.
- DEFAULT_DIV, 16'd16, reset value of BAUDDIV in clock cycles per bit.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous reset, active-low
- cs  input  1  LSU chip select, valid this cycle
- wr  input  1  1 = store, 0 = load (qualified by cs)
- mask  input  4  byte enables for stores; mask[i] covers data_wr[8i+7:8i]
- addr  input  32  byte address from LSU
- data_wr  input  32  store data
- data_rd  output  32  load data, combinational, same cycle as cs&!wr
- tx  output  1  serial line, idles high
- irq  output  1  TX-done interrupt, level

Behaviour:
- Decode: hit = cs & (addr[31:4]==BASE_ADDR[31:4]). addr[3:2] selects the register; addr[1:0] is ignored.
- On a miss, data_rd=0 and no state changes.
- 0x0 TXDATA (W): store with mask[0]=1 pushes data_wr[7:0]. Reads return 0.
- 0x4 STATUS (R/W1C):
  - [0] full; [1] empty; [2] busy (FSM≠IDLE); [3] overflow (sticky); [7:4] FIFO count, saturating at 15; others 0.
  - A store with mask[0]=1 and data_wr[3]=1 clears overflow. Other bits are read-only.
- 0x8 BAUDDIV (RW): [15:0] bit period in cycles, written per byte via mask[1:0]. A stored value of 0 is used as 1. Reads return {16'b0,div}.
- 0xC CTRL (RW, mask[0]): [0] enable (reset 1); [1] irq_en (reset 0).
- Reset (rst=0, asynchronous):
  - tx=1, irq=0, FIFO empty, overflow=0, div=DEFAULT_DIV, CTRL=2'b01, FSM=IDLE, counters 0.
  - A reset mid-frame aborts the frame immediately; tx goes high.
- FIFO: registered push on the clk edge with the store.
  - Push when full and no pop that cycle: byte dropped, overflow←1.
  - Push and pop in the same cycle while full: accepted, count unchanged.
  - Pointers wrap mod FIFO_DEPTH.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if enable & !empty, pop the head into the shift register, set bitcnt=0 and baudcnt=0, go to START. tx=1 in IDLE.
  - START: tx=0 for div cycles, then go to DATA.
  - DATA: tx=shift[0] for div cycles per bit, LSB first. Shift right after each bit. After bit 7 (bitcnt=7 done), go to STOP.
  - STOP: tx=1 for div cycles. At the end, if enable & !empty, pop and go directly to START (no idle gap); else go to IDLE.
  - baudcnt counts 0..div-1; the bit boundary is baudcnt==div-1.
  - div is sampled at each bit boundary, so a BAUDDIV write mid-frame takes effect from the next bit.
- Latency: a byte pushed at edge N into an empty FIFO with FSM IDLE and enable=1 is popped at edge N+1; tx falls after edge N+1. One frame = 10·div cycles.
- enable=0: the current frame completes normally. No new pop occurs; FIFO contents are retained.
- tx and irq are driven from flops (glitch-free). irq = irq_en & empty & (FSM==IDLE).
- Loads have no side effects (no pop-on-read).

Test Plan:
- Reset, then load STATUS -> data_rd=32'h0000_0002 (empty), tx=1, BAUDDIV reads 16; irq=0.
- Store 8'hA5 to TXDATA with div=4 -> tx low 4 cycles starting 1 cycle after the store, then bits 1,0,1,0,0,1,0,1 each 4 cycles, then high 4 cycles; busy clears at 40 cycles.
- 9 back-to-back stores with DEPTH=8 while FSM IDLE and enable=0 -> count=8, full=1, overflow=1, 9th byte lost. Store STATUS data_wr=8 -> overflow=0. Set enable -> 8 frames with no idle gap between them.
- Store to a full FIFO in the same cycle as the STOP-end pop -> byte accepted, overflow stays 0, count stays 8.
- Assert rst low mid-DATA bit 3 -> tx=1 immediately (asynchronously), FIFO empty, div=16, CTRL=1. After release the FSM stays IDLE.
- Store with cs=1 to BASE_ADDR+0x10 and with mask=4'b0010 to TXDATA -> no push, STATUS unchanged; irq_en=1 with empty FIFO and IDLE -> irq=1.
